// File: rtl/eth_tx_frame_ctrl.sv
// eth_tx_frame_ctrl: Gigabit Ethernet transmit frame sequencer.
// Takes destination MAC .. payload bytes over valid/ready. Drives GMII with
// preamble, SFD, payload, optional zero pad, FCS and inter-frame gap.
// The FCS comes from an external CRC32_D8 engine sequenced via crc_init/crc_en.
// Optional feature macro: ETH_TX_PAD_EN pads frames shorter than MIN_FRAME with
// zeros (pad included in the CRC). When it is undefined, frames go out unpadded.
module eth_tx_frame_ctrl #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int MIN_FRAME    = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        crc_init,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_value,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        frame_done,
  output logic        underrun
);

`ifdef ETH_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [7:0]  PRE_LAST    = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST    = 8'(IFG_LEN - 1);
  localparam logic [15:0] MIN_FRAME_W = 16'(MIN_FRAME);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] fcs_q, fcs_d;
  logic        aborted_q, aborted_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;

  logic [15:0] byte_cnt_inc;
  logic        pad_needed;

  // Saturating byte count and the short-frame decision taken on the last byte
  always_comb begin
    byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? 16'hFFFF : byte_cnt_q + 16'd1;
    pad_needed   = PAD_EN && (byte_cnt_inc < MIN_FRAME_W);
  end

  // State, counter and registered GMII output storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fcs_idx_q    <= '0;
      byte_cnt_q   <= '0;
      fcs_q        <= '0;
      aborted_q    <= 1'b0;
      txd_q        <= '0;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fcs_idx_q    <= fcs_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      fcs_q        <= fcs_d;
      aborted_q    <= aborted_d;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next-state logic; the last gap cycle doubles as the idle decision so that
  // back-to-back frames are separated by exactly IFG_LEN idle wire cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (s_valid) state_d = S_PREAMBLE;
      S_PREAMBLE: if (cnt_q == PRE_LAST) state_d = S_SFD;
      S_SFD:      state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (!s_valid)   state_d = S_DRAIN;
        else if (s_last) state_d = pad_needed ? S_PAD : S_FCS;
      end
      S_PAD:      if (byte_cnt_inc >= MIN_FRAME_W) state_d = S_FCS;
      S_FCS:      if (fcs_idx_q == 2'd3) state_d = S_IFG;
      S_IFG:      if (cnt_q == IFG_LAST) state_d = s_valid ? S_PREAMBLE : S_IDLE;
      S_DRAIN:    if (s_valid && s_last) state_d = S_IFG;
      default:    state_d = S_IDLE;
    endcase
  end

  // Per-state outputs: combinational handshake/CRC controls and next values
  // of the registered wire signals and counters
  always_comb begin
    s_ready      = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    crc_data     = 8'h00;
    cnt_d        = '0;
    fcs_idx_d    = '0;
    byte_cnt_d   = byte_cnt_q;
    fcs_d        = fcs_q;
    aborted_d    = aborted_q;
    txd_d        = 8'h00;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    case (state_q)
      S_PREAMBLE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
        cnt_d   = (cnt_q == PRE_LAST) ? 8'd0 : cnt_q + 8'd1;
      end
      S_SFD: begin
        txd_d      = 8'hD5;
        tx_en_d    = 1'b1;
        crc_init   = 1'b1;
        byte_cnt_d = '0;
        aborted_d  = 1'b0;
      end
      S_PAYLOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          crc_en     = 1'b1;
          crc_data   = s_data;
          txd_d      = s_data;
          tx_en_d    = 1'b1;
          byte_cnt_d = byte_cnt_inc;
        end else begin
          // Starved mid-frame: mark the frame bad on the wire and abort it
          tx_en_d    = 1'b1;
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          aborted_d  = 1'b1;
        end
      end
      S_PAD: begin
        crc_en     = 1'b1;
        tx_en_d    = 1'b1;
        byte_cnt_d = byte_cnt_inc;
      end
      S_FCS: begin
        tx_en_d   = 1'b1;
        fcs_idx_d = fcs_idx_q + 2'd1;
        case (fcs_idx_q)
          2'd0: begin
            // CRC engine absorbed the final byte on the previous edge
            fcs_d = crc_value;
            txd_d = crc_value[7:0];
          end
          2'd1:    txd_d = fcs_q[15:8];
          2'd2:    txd_d = fcs_q[23:16];
          default: txd_d = fcs_q[31:24];
        endcase
      end
      S_IFG: begin
        cnt_d        = (cnt_q == IFG_LAST) ? 8'd0 : cnt_q + 8'd1;
        frame_done_d = (cnt_q == 8'd0) && !aborted_q;
      end
      S_DRAIN: s_ready = 1'b1;
      default: ;
    endcase
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Testbench for eth_tx_frame_ctrl: directed frames, wire capture, CRC engine model.
`timescale 1ns/1ps
module tb_eth_tx_frame_ctrl;

  localparam int PRE  = 7;
  localparam int IFG  = 12;
  localparam int MINF = 60;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        crc_init;
  logic        crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_value;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        frame_done;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  eth_tx_frame_ctrl #(.PREAMBLE_LEN(PRE), .IFG_LEN(IFG), .MIN_FRAME(MINF)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .crc_init(crc_init), .crc_en(crc_en), .crc_data(crc_data),
    .crc_value(crc_value), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er), .frame_done(frame_done), .underrun(underrun)
  );

  always #4 clk = ~clk;

  // Reflected CRC-32 byte update (poly 0xEDB88320)
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] crc32(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) c = crc_step(c, d[i]);
    return ~c;
  endfunction

  // External CRC32_D8 engine model
  logic [31:0] crc_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        crc_reg <= 32'hFFFFFFFF;
    else if (crc_init) crc_reg <= 32'hFFFFFFFF;
    else if (crc_en)   crc_reg <= crc_step(crc_reg, crc_data);
  end
  assign crc_value = ~crc_reg;

  // Wire capture
  logic [7:0] byte_log[$];
  int frame_len_q[$];
  int frame_start_q[$];
  int gap_q[$];
  int fd_cnt = 0, fd_al = 0, ur_cnt = 0, er_cnt = 0, er_en_cnt = 0;

  initial begin
    int run;
    int gap_cnt;
    run = 0;
    gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        fd_cnt++;
        if (!gmii_tx_en && run > 0) fd_al++;
      end
      if (underrun) ur_cnt++;
      if (gmii_tx_er) begin
        er_cnt++;
        if (gmii_tx_en) er_en_cnt++;
      end
      if (gmii_tx_en) begin
        if (run == 0) begin
          gap_q.push_back(gap_cnt);
          frame_start_q.push_back(byte_log.size());
        end
        byte_log.push_back(gmii_txd);
        run++;
        gap_cnt = 0;
      end else begin
        if (run > 0) begin
          frame_len_q.push_back(run);
          run = 0;
        end
        gap_cnt++;
      end
    end
  end

  function automatic bq_t seq(input int base, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(base + i));
    return q;
  endfunction

  function automatic bq_t exp_frame(input bq_t pl);
    bq_t f;
    bq_t body;
    logic [31:0] c;
    body = pl;
    if (PAD) while (body.size() < MINF) body.push_back(8'h00);
    for (int i = 0; i < PRE; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (body[i]) f.push_back(body[i]);
    c = crc32(body);
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    f.push_back(c[23:16]);
    f.push_back(c[31:24]);
    return f;
  endfunction

  // Number of differing bytes/length between captured frame idx and exp (-1: absent)
  function automatic int frame_diff(input int idx, input bq_t exp);
    int mm;
    int st;
    mm = 0;
    if (idx >= frame_len_q.size()) return -1;
    if (frame_len_q[idx] != exp.size()) mm++;
    st = frame_start_q[idx];
    for (int i = 0; i < exp.size(); i++)
      if (st + i >= byte_log.size() || byte_log[st + i] !== exp[i]) mm++;
    return mm;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    s_data = d;
    s_valid = 1'b1;
    s_last = last;
    @(negedge clk);
    while (!s_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL push_byte_accept: s_ready=%b required 1 within 1000 cycles", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bq_t d, input int stall_after, input int stall_cycles,
                            input bit keep_valid);
    for (int i = 0; i < d.size(); i++) begin
      if (i == stall_after && stall_cycles > 0) begin
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (stall_cycles) @(posedge clk);
        #1;
      end
      push_byte(d[i], i == d.size() - 1);
    end
    if (!keep_valid) begin
      s_valid = 1'b0;
      s_last = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target, input int tail);
    int guard;
    guard = 0;
    while (frame_len_q.size() < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (frame_len_q.size() < target) begin
      errors++;
      $display("FAIL wait_frames: frames=%0d required %0d", frame_len_q.size(), target);
    end
    repeat (tail) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 8'h00;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gmii_tx_en, gmii_tx_er, gmii_txd} !== 10'h000) begin
      errors++;
      $display("FAIL reset_gmii: en/er/txd=%b/%b/%h required 0/0/00", gmii_tx_en, gmii_tx_er, gmii_txd);
    end
    checks++;
    if ({s_ready, crc_init, crc_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/init/en=%b%b%b required 000", s_ready, crc_init, crc_en);
    end
    checks++;
    if ({frame_done, underrun} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses: done/underrun=%b%b required 00", frame_done, underrun);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({gmii_tx_en, s_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: en/ready=%b%b required 00", gmii_tx_en, s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame64();
    int n0, fd0, al0, er0;
    bq_t pl;
    pl = seq(0, 64);
    n0 = frame_len_q.size();
    fd0 = fd_cnt;
    al0 = fd_al;
    er0 = er_cnt;
    s_data = pl[0];
    s_last = 1'b0;
    s_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gmii_tx_en !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle1: tx_en=%b required 0", gmii_tx_en);
    end
    @(negedge clk);
    checks++;
    if (gmii_tx_en !== 1'b1 || gmii_txd !== 8'h55) begin
      errors++;
      $display("FAIL latency_cycle2: tx_en/txd=%b/%h required 1/55", gmii_tx_en, gmii_txd);
    end
    push_frame(pl, -1, 0, 1'b0);
    wait_frames(n0 + 1, 16);
    checks++;
    if (frame_len_q.size() <= n0 || frame_len_q[n0] !== 76) begin
      errors++;
      $display("FAIL frame64_len: len=%0d required 76",
               (frame_len_q.size() > n0) ? frame_len_q[n0] : -1);
    end
    checks++;
    if (frame_diff(n0, exp_frame(pl)) !== 0) begin
      errors++;
      $display("FAIL frame64_bytes: mismatches=%0d required 0", frame_diff(n0, exp_frame(pl)));
    end
    checks++;
    if (fd_cnt - fd0 !== 1 || fd_al - al0 !== 1) begin
      errors++;
      $display("FAIL frame64_done: pulses=%0d aligned=%0d required 1/1", fd_cnt - fd0, fd_al - al0);
    end
    checks++;
    if (er_cnt - er0 !== 0) begin
      errors++;
      $display("FAIL frame64_tx_er: count=%0d required 0", er_cnt - er0);
    end
  endtask

  task automatic test_pad();
    int n0, exp_len;
    bq_t pl;
    pl = seq(8'h10, 14);
`ifdef ETH_TX_PAD_EN
    exp_len = 8 + 60 + 4;
`else
    exp_len = 8 + 14 + 4;
`endif
    n0 = frame_len_q.size();
    push_frame(pl, -1, 0, 1'b0);
    wait_frames(n0 + 1, 16);
    checks++;
    if (frame_len_q.size() <= n0 || frame_len_q[n0] !== exp_len) begin
      errors++;
      $display("FAIL pad_len: len=%0d required %0d",
               (frame_len_q.size() > n0) ? frame_len_q[n0] : -1, exp_len);
    end
    checks++;
    if (frame_diff(n0, exp_frame(pl)) !== 0) begin
      errors++;
      $display("FAIL pad_bytes: mismatches=%0d required 0", frame_diff(n0, exp_frame(pl)));
    end
  endtask

  task automatic test_underrun();
    int n0, ur0, er0, een0, fd0, st;
    bq_t pl;
    pl = seq(8'h40, 64);
    n0 = frame_len_q.size();
    ur0 = ur_cnt;
    er0 = er_cnt;
    een0 = er_en_cnt;
    fd0 = fd_cnt;
    push_frame(pl, 20, 3, 1'b0);
    wait_frames(n0 + 1, 20);
    checks++;
    if (frame_len_q.size() !== n0 + 1 || frame_len_q[n0] !== 29) begin
      errors++;
      $display("FAIL underrun_len: frames=%0d len=%0d required %0d/29", frame_len_q.size(),
               (frame_len_q.size() > n0) ? frame_len_q[n0] : -1, n0 + 1);
    end
    st = (frame_start_q.size() > n0) ? frame_start_q[n0] : 0;
    checks++;
    if (byte_log.size() < st + 29 || byte_log[st + 27] !== 8'h53 || byte_log[st + 28] !== 8'h00) begin
      errors++;
      $display("FAIL underrun_bytes: last two=%h %h required 53 00",
               byte_log[st + 27], byte_log[st + 28]);
    end
    checks++;
    if (ur_cnt - ur0 !== 1) begin
      errors++;
      $display("FAIL underrun_pulse: count=%0d required 1", ur_cnt - ur0);
    end
    checks++;
    if (er_cnt - er0 !== 1 || er_en_cnt - een0 !== 1) begin
      errors++;
      $display("FAIL underrun_tx_er: er=%0d er_with_en=%0d required 1/1", er_cnt - er0, er_en_cnt - een0);
    end
    checks++;
    if (fd_cnt - fd0 !== 0) begin
      errors++;
      $display("FAIL underrun_no_done: frame_done=%0d required 0", fd_cnt - fd0);
    end
  endtask

  task automatic test_known_vector();
    int n0, st;
    bq_t pl;
    pl = seq(8'h31, 9);
    n0 = frame_len_q.size();
    push_frame(pl, -1, 0, 1'b0);
    wait_frames(n0 + 1, 16);
    checks++;
    if (frame_diff(n0, exp_frame(pl)) !== 0) begin
      errors++;
      $display("FAIL known_frame: mismatches=%0d required 0", frame_diff(n0, exp_frame(pl)));
    end
`ifndef ETH_TX_PAD_EN
    st = (frame_start_q.size() > n0) ? frame_start_q[n0] : 0;
    checks++;
    if (byte_log.size() < st + 21 ||
        {byte_log[st + 17], byte_log[st + 18], byte_log[st + 19], byte_log[st + 20]} !== 32'h2639F4CB) begin
      errors++;
      $display("FAIL known_fcs: bytes=%h %h %h %h required 26 39 F4 CB",
               byte_log[st + 17], byte_log[st + 18], byte_log[st + 19], byte_log[st + 20]);
    end
`else
    st = 0;
`endif
  endtask

  task automatic test_back_to_back();
    int n0, fd0;
    bq_t a, b;
    a = seq(8'h00, 64);
    b = seq(8'h80, 64);
    n0 = frame_len_q.size();
    fd0 = fd_cnt;
    push_frame(a, -1, 0, 1'b1);
    push_frame(b, -1, 0, 1'b0);
    wait_frames(n0 + 2, 16);
    checks++;
    if (frame_diff(n0, exp_frame(a)) !== 0) begin
      errors++;
      $display("FAIL b2b_frame_a: mismatches=%0d required 0", frame_diff(n0, exp_frame(a)));
    end
    checks++;
    if (frame_diff(n0 + 1, exp_frame(b)) !== 0) begin
      errors++;
      $display("FAIL b2b_frame_b: mismatches=%0d required 0", frame_diff(n0 + 1, exp_frame(b)));
    end
    checks++;
    if (gap_q.size() <= n0 + 1 || gap_q[n0 + 1] !== IFG) begin
      errors++;
      $display("FAIL b2b_gap: idle=%0d required %0d",
               (gap_q.size() > n0 + 1) ? gap_q[n0 + 1] : -1, IFG);
    end
    checks++;
    if (fd_cnt - fd0 !== 2) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d required 2", fd_cnt - fd0);
    end
  endtask

  task automatic test_reset_in_fcs();
    int n0, fd0;
    bq_t pl;
    pl = seq(8'h31, 9);
    n0 = frame_len_q.size();
    fd0 = fd_cnt;
    push_frame(pl, -1, 0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gmii_tx_en, gmii_tx_er, gmii_txd} !== 10'h000) begin
      errors++;
      $display("FAIL fcs_reset_gmii: en/er/txd=%b/%b/%h required 0/0/00", gmii_tx_en, gmii_tx_er, gmii_txd);
    end
    checks++;
    if ({s_ready, crc_en, crc_init} !== 3'b000) begin
      errors++;
      $display("FAIL fcs_reset_ctrl: ready/crc_en/crc_init=%b%b%b required 000", s_ready, crc_en, crc_init);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(n0 + 1, 4);
    checks++;
    if (frame_len_q.size() <= n0 || frame_len_q[n0] !== 17) begin
      errors++;
      $display("FAIL fcs_reset_cut: len=%0d required 17",
               (frame_len_q.size() > n0) ? frame_len_q[n0] : -1);
    end
    push_frame(pl, -1, 0, 1'b0);
    wait_frames(n0 + 2, 16);
    checks++;
    if (frame_diff(n0 + 1, exp_frame(pl)) !== 0) begin
      errors++;
      $display("FAIL fcs_reset_recover: mismatches=%0d required 0", frame_diff(n0 + 1, exp_frame(pl)));
    end
    checks++;
    if (fd_cnt - fd0 !== 1) begin
      errors++;
      $display("FAIL fcs_reset_done: pulses=%0d required 1", fd_cnt - fd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame64();
    test_pad();
    test_underrun();
    test_known_vector();
    test_back_to_back();
    test_reset_in_fcs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
